fcall_initiator: RTL and testbench

- Caller-side driver for compiled function blocks that use the level `ready` / `done` call protocol, including tail-recursive loop blocks and purely combinational blocks.
- Accepts argument tuples from a host request port and holds them stable on the callee's argument bus. It then drives the callee's `ready`, waits for a valid `done`, captures the result and presents it on a response port.
- Forces the callee's `ready` low between calls so the callee re-arms.
- Sits between a testbench or host sequencer and any generated function instance.

---
 rtl/fcall_initiator_if.sv | 23 ++
 rtl/fcall_initiator.sv | 131 +++++++++++++
 tb/tb_fcall_initiator.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcall_initiator_if.sv
// Host-side request/response port of fcall_initiator: argument tuples in, callee results out.
interface fcall_initiator_if #(
  parameter int WIDTH = 8,
  parameter int NARGS = 3
) ();
  logic                   req_valid;
  logic                   req_ack;
  logic [NARGS*WIDTH-1:0] req_args;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_result;
  logic                   rsp_timeout;

  modport master (
    output req_valid, req_args, rsp_ready,
    input  req_ack, rsp_valid, rsp_result, rsp_timeout
  );

  modport slave (
    input  req_valid, req_args, rsp_ready,
    output req_ack, rsp_valid, rsp_result, rsp_timeout
  );
endinterface

// File: rtl/fcall_initiator.sv
// Caller-side driver for level ready/done function blocks: holds arguments, raises ready,
// masks stale done, captures the result (or a timeout) and re-arms the callee between calls.
module fcall_initiator #(
  parameter int WIDTH        = 8,
  parameter int NARGS        = 3,
  parameter int DONE_MASK    = 2,
  parameter int REARM_CYCLES = 1,
  parameter int TIMEOUT      = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  fcall_initiator_if.slave       host,
  output logic                   fn_ready,
  input  logic                   fn_done,
  output logic [NARGS*WIDTH-1:0] fn_args,
  input  logic [WIDTH-1:0]       fn_result,
  output logic                   busy,
  output logic [15:0]            call_count
);
  localparam int MW = (DONE_MASK > 1)    ? $clog2(DONE_MASK + 1)    : 1;
  localparam int RW = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT > 1)      ? $clog2(TIMEOUT + 1)      : 1;

  typedef enum logic [1:0] {S_IDLE, S_MASK, S_WAIT, S_REARM} state_t;

  state_t                 state_q, state_d;
  logic [MW-1:0]          mask_q, mask_d;
  logic [RW-1:0]          rearm_q, rearm_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   fn_ready_q, fn_ready_d;
  logic [NARGS*WIDTH-1:0] fn_args_q, fn_args_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]       rsp_result_q, rsp_result_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic [15:0]            call_count_q, call_count_d;

  logic ack;
  logic tmo_hit;

  // A request is taken only while idle and the response slot is free or draining this edge.
  assign ack     = (state_q == S_IDLE) && host.req_valid && (!rsp_valid_q || host.rsp_ready);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT));

  // NOTE: every _d gets its hold value before the case, so no path through this block
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    rearm_d       = rearm_q;
    tmo_d         = tmo_q;
    fn_ready_d    = fn_ready_q;
    fn_args_d     = fn_args_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    call_count_d  = call_count_q;

    if (rsp_valid_q && host.rsp_ready) rsp_valid_d = 1'b0;
    if (fn_ready_q && (tmo_q != TW'(TIMEOUT))) tmo_d = tmo_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (ack) begin
          fn_args_d  = host.req_args;
          fn_ready_d = 1'b1;
          mask_d     = MW'(DONE_MASK);
          tmo_d      = TW'(1);
          state_d    = (DONE_MASK == 0) ? S_WAIT : S_MASK;
        end
      end
      S_MASK: begin
        mask_d = mask_q - MW'(1);
        if (mask_q == MW'(1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout landing on the same edge
        if (fn_done || tmo_hit) begin
          rsp_result_d  = fn_done ? fn_result : '0;
          rsp_timeout_d = !fn_done;
          rsp_valid_d   = 1'b1;
          fn_ready_d    = 1'b0;
          call_count_d  = call_count_q + 16'd1;
          rearm_d       = RW'(REARM_CYCLES);
          state_d       = S_REARM;
        end
      end
      S_REARM: begin
        rearm_d = rearm_q - RW'(1);
        if (rearm_q == RW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      rearm_q       <= '0;
      tmo_q         <= '0;
      fn_ready_q    <= 1'b0;
      fn_args_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      call_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      rearm_q       <= rearm_d;
      tmo_q         <= tmo_d;
      fn_ready_q    <= fn_ready_d;
      fn_args_q     <= fn_args_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      call_count_q  <= call_count_d;
    end
  end

  // req_ack is gated by reset because the idle decode alone would let it follow req_valid.
  assign host.req_ack     = ack && !reset;
  assign host.rsp_valid   = rsp_valid_q;
  assign host.rsp_result  = rsp_result_q;
  assign host.rsp_timeout = rsp_timeout_q;
  assign fn_ready         = fn_ready_q;
  assign fn_args          = fn_args_q;
  assign busy             = (state_q != S_IDLE);
  assign call_count       = call_count_q;
endmodule

// File: tb/tb_fcall_initiator.sv
// Bench for fcall_initiator: behavioural callees, an edge-timestamp reference model checked
// every cycle, and directed calls with hand-computed results.
module tb_fcall_initiator;
  localparam longint DM  = 2;
  localparam longint RC  = 1;
  localparam longint TMO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        fn_ready, fn_done, busy;
  logic [31:0] fn_args;
  logic [7:0]  fn_result;
  logic [15:0] call_count;
  logic [15:0] cnt_offset;

  fcall_initiator_if #(.WIDTH(8), .NARGS(4)) host ();

  fcall_initiator #(.WIDTH(8), .NARGS(4), .DONE_MASK(2), .REARM_CYCLES(1), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .host(host),
    .fn_ready(fn_ready), .fn_done(fn_done), .fn_args(fn_args), .fn_result(fn_result),
    .busy(busy), .call_count(call_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural callees ----------------
  typedef enum {M_FIB, M_POLY, M_STUCK, M_STALE} mode_t;
  mode_t       mode;
  logic        loaded = 1'b0;
  logic [7:0]  cn = 8'd0, ca = 8'd0, cb = 8'd0;
  int unsigned cyc = 0;
  logic [7:0]  a, b, c, d, poly;

  assign a = fn_args[7:0];
  assign b = fn_args[15:8];
  assign c = fn_args[23:16];
  assign d = fn_args[31:24];
  assign poly = a * b * b + c * a + d;

  // fib(n, a, b): tail-recursive loop, one iteration per cycle while ready is high
  always @(posedge clock) begin
    if (!fn_ready) begin
      loaded <= 1'b0;
      cyc    <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!loaded) begin
        loaded <= 1'b1;
        ca <= a; cb <= b; cn <= c;
      end else if (cn != 8'd0) begin
        cn <= cn - 8'd1; ca <= cb; cb <= ca + cb;
      end
    end
  end

  always_comb begin
    fn_done   = 1'b0;
    fn_result = 8'h00;
    case (mode)
      M_FIB:   begin fn_done = fn_ready && loaded && (cn == 8'd0); fn_result = ca; end
      M_POLY:  begin fn_done = fn_ready; fn_result = poly; end
      M_STALE: begin
        if (fn_ready && cyc < 2)       begin fn_done = 1'b1; fn_result = 8'hEE; end
        else if (fn_ready && cyc >= 5) begin fn_done = 1'b1; fn_result = a ^ b; end
      end
      default: ;
    endcase
  end

  // ---------------- reference model (edge timestamps) ----------------
  longint     edge_n = 0;
  logic       m_active;
  longint     m_acc, m_end;
  logic [31:0] m_args;
  logic       m_rsp_valid, m_tmo;
  logic [7:0] m_res;
  logic [15:0] m_count;

  function automatic logic busy_after(input longint k);
    return m_active || (k < m_end + RC);
  endfunction

  initial begin
    logic   exp_ack, consume;
    longint age;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_active = 1'b0; m_acc = 0; m_end = -100; m_args = '0;
        m_rsp_valid = 1'b0; m_tmo = 1'b0; m_res = '0; m_count = '0;
      end else begin
        edge_n++;
        exp_ack = !busy_after(edge_n - 1) && host.req_valid && (!m_rsp_valid || host.rsp_ready);
        check("req_ack", 32'(host.req_ack), 32'(exp_ack));
        consume = m_rsp_valid && host.rsp_ready;
        if (consume) m_rsp_valid = 1'b0;
        if (m_active) begin
          age = edge_n - m_acc;
          if (age >= DM + 1 && (fn_done || age >= TMO)) begin
            m_res       = fn_done ? fn_result : 8'h00;
            m_tmo       = !fn_done;
            m_rsp_valid = 1'b1;
            m_active    = 1'b0;
            m_end       = edge_n;
            m_count     = m_count + 16'd1;
          end
        end else if (exp_ack) begin
          m_args   = host.req_args;
          m_acc    = edge_n;
          m_active = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("fn_ready",    32'(fn_ready),         32'(m_active));
        check("busy",        32'(busy),             32'(busy_after(edge_n)));
        check("rsp_valid",   32'(host.rsp_valid),   32'(m_rsp_valid));
        check("rsp_result",  32'(host.rsp_result),  32'(m_res));
        check("rsp_timeout", 32'(host.rsp_timeout), 32'(m_tmo));
        check("call_count",  32'(call_count),       32'(16'(m_count + cnt_offset)));
        check("fn_args",     fn_args,               m_args);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ack(input string name, output time t);
    t = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      if (host.req_ack) begin t = $time; return; end
    end
    check({name, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    for (int i = 0; i < 60; i++) begin
      if (host.rsp_valid) return;
      @(negedge clock);
    end
    check({name, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic call(input string name, input mode_t m, input logic [31:0] args);
    time t;
    @(negedge clock);
    mode = m; host.req_args = args; host.req_valid = 1'b1;
    wait_ack(name, t);
    @(negedge clock);
    host.req_valid = 1'b0;
    wait_rsp(name);
  endtask

  task automatic drain();
    host.rsp_ready = 1'b1;
    @(negedge clock);
    host.rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1, t2, t3;
    int  hi, acks;
    reset = 1'b1; cnt_offset = '0; mode = M_FIB;
    host.req_valid = 1'b1; host.req_args = 32'hFFFF_FFFF; host.rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_req_ack",    32'(host.req_ack),   32'd0);
    check("rst_fn_ready",   32'(fn_ready),       32'd0);
    check("rst_rsp_valid",  32'(host.rsp_valid), 32'd0);
    check("rst_call_count", 32'(call_count),     32'd0);
    host.req_valid = 1'b0;
    reset = 1'b0;

    // fib(10) with a=0, b=1
    call("fib10", M_FIB, {8'd0, 8'd10, 8'd1, 8'd0});
    check("fib10_result",  32'(host.rsp_result),  32'd55);
    check("fib10_timeout", 32'(host.rsp_timeout), 32'd0);
    check("fib10_count",   32'(call_count),       32'd1);
    check("fib10_ready",   32'(fn_ready),         32'd0);
    @(negedge clock);
    check("fib10_idle", 32'(busy), 32'd0);
    drain();

    // combinational polynomial, back-to-back with rsp_ready tied high
    mode = M_POLY; host.rsp_ready = 1'b1;
    host.req_args = {8'd5, 8'd4, 8'd3, 8'd2}; host.req_valid = 1'b1;
    wait_ack("poly1", t1);
    wait_ack("poly2", t2);
    wait_ack("poly3", t3);
    check("poly_spacing12", 32'((t2 - t1) / 10), 32'd5);
    check("poly_spacing23", 32'((t3 - t2) / 10), 32'd5);
    @(negedge clock);
    host.req_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("poly_lat_early", 32'(host.rsp_valid), 32'd0);
    @(negedge clock);
    check("poly_lat_valid", 32'(host.rsp_valid),  32'd1);
    check("poly_result",    32'(host.rsp_result), 32'd31);
    repeat (3) @(negedge clock);

    // backpressure: response held, second request waits, then same-edge consume + accept
    host.rsp_ready = 1'b0;
    host.req_args = {8'd5, 8'd4, 8'd3, 8'd2}; host.req_valid = 1'b1;
    wait_ack("bpA", t1);
    @(negedge clock);
    host.req_args = {8'd4, 8'd3, 8'd2, 8'd1};
    wait_rsp("bpA");
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      if (host.req_ack) acks++;
    end
    @(negedge clock);
    check("bp_no_ack",  32'(acks),            32'd0);
    check("bp_hold",    32'(host.rsp_result), 32'd31);
    host.rsp_ready = 1'b1;
    @(posedge clock);
    check("bp_same_edge_ack", 32'(host.req_ack),   32'd1);
    check("bp_same_edge_rsp", 32'(host.rsp_valid), 32'd1);
    @(negedge clock);
    host.req_valid = 1'b0; host.rsp_ready = 1'b0;
    check("bp_consumed", 32'(host.rsp_valid), 32'd0);
    wait_rsp("bpB");
    check("bpB_result", 32'(host.rsp_result), 32'd11);
    drain();

    // timeout: done stuck low
    @(negedge clock);
    mode = M_STUCK; host.req_args = 32'd7; host.req_valid = 1'b1;
    wait_ack("tmo", t1);
    @(negedge clock);
    host.req_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (host.rsp_valid) break;
      if (fn_ready) hi++;
      @(negedge clock);
    end
    check("tmo_ready_cycles", 32'(hi),                32'd16);
    check("tmo_valid",        32'(host.rsp_valid),    32'd1);
    check("tmo_result",       32'(host.rsp_result),   32'd0);
    check("tmo_flag",         32'(host.rsp_timeout),  32'd1);
    check("tmo_ready_low",    32'(fn_ready),          32'd0);
    check("tmo_count",        32'(call_count),        32'd7);
    drain();

    call("fib6", M_FIB, {8'd0, 8'd6, 8'd1, 8'd0});
    check("fib6_result",  32'(host.rsp_result),  32'd8);
    check("fib6_timeout", 32'(host.rsp_timeout), 32'd0);
    drain();

    // stale done during the mask window
    call("stale", M_STALE, {8'd0, 8'd0, 8'h3C, 8'hA5});
    check("stale_result",  32'(host.rsp_result),  32'h99);
    check("stale_timeout", 32'(host.rsp_timeout), 32'd0);
    drain();

    // asynchronous reset in the middle of WAIT
    @(negedge clock);
    mode = M_STUCK; host.req_args = 32'h1234_5678; host.req_valid = 1'b1;
    wait_ack("rstw", t1);
    @(negedge clock);
    repeat (4) @(negedge clock);
    check("rstw_in_call", 32'(fn_ready), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstw_fn_ready",   32'(fn_ready),          32'd0);
    check("rstw_busy",       32'(busy),              32'd0);
    check("rstw_req_ack",    32'(host.req_ack),      32'd0);
    check("rstw_rsp_valid",  32'(host.rsp_valid),    32'd0);
    check("rstw_rsp_result", 32'(host.rsp_result),   32'd0);
    check("rstw_count",      32'(call_count),        32'd0);
    check("rstw_fn_args",    fn_args,                32'd0);
    @(negedge clock);
    reset = 1'b0; host.req_valid = 1'b0;
    repeat (2) @(negedge clock);

    // call_count wrap: preload the state left by 65535 calls, then complete one more
    @(posedge clock);
    #1;
    force dut.call_count_q = 16'hFFFF;
    cnt_offset = 16'hFFFF;
    #1;
    release dut.call_count_q;
    @(negedge clock);
    check("wrap_preload", 32'(call_count), 32'h0000_FFFF);
    call("wrap", M_POLY, {8'd5, 8'd4, 8'd3, 8'd2});
    check("wrap_result", 32'(host.rsp_result), 32'd31);
    check("wrap_count",  32'(call_count),      32'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
